// File: rtl/uart_rx_8x.sv
// 8x-oversampling UART receiver (8N1, LSB first). Start-bit validation,
// 3-sample majority vote per bit, held data word with a one-cycle strobe.
`timescale 1ns/1ps

module uart_rx_8x #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       baud8_tick,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_strobe,
    output logic       framing_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;

    state_t     state_q;
    logic [2:0] phase_q;
    logic [2:0] bit_idx_q;
    logic       s3_q;
    logic       s4_q;
    logic       armed_q;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic       vote_s;
    logic       in_frame_s;
    logic [7:0] rx_data_q;
    logic       rx_strobe_q;
    logic       framing_err_q;
    logic       busy_q;

    // Synchroniser resets to the idle-high line level.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // Majority vote and next shift-register value; upper bits stay zero for short words.
    always_comb begin
        vote_s                = maj3(s3_q, s4_q, rxd_s);
        shift_d               = shift_q >> 1;
        shift_d[DATA_BITS-1]  = vote_s;
        in_frame_s            = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    end

    // Receive FSM: all state advances only on baud8_tick; strobes are one sys_clk wide.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            phase_q       <= 3'd0;
            bit_idx_q     <= 3'd0;
            s3_q          <= 1'b1;
            s4_q          <= 1'b1;
            armed_q       <= 1'b0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_strobe_q   <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            rx_strobe_q   <= 1'b0;
            framing_err_q <= 1'b0;
            if (baud8_tick) begin
                if (in_frame_s) begin
                    phase_q <= phase_q + 3'd1;
                    if (phase_q == 3'd3) begin
                        s3_q <= rxd_s;
                    end
                    if (phase_q == 3'd4) begin
                        s4_q <= rxd_s;
                    end
                end
                case (state_q)
                    S_IDLE: begin
                        if (armed_q && !rxd_s) begin
                            // This tick is phase 0 of the start bit.
                            state_q <= S_START;
                            phase_q <= 3'd1;
                            armed_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else if (rxd_s) begin
                            armed_q <= 1'b1;
                        end
                    end
                    S_START: begin
                        if ((phase_q == 3'd5) && vote_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else if (phase_q == 3'd7) begin
                            state_q   <= S_DATA;
                            bit_idx_q <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        if (phase_q == 3'd5) begin
                            shift_q <= shift_d;
                        end
                        if (phase_q == 3'd7) begin
                            if (bit_idx_q == LAST_BIT) begin
                                state_q <= S_STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end
                    end
                    S_STOP: begin
                        // Leave at phase 5 so a back-to-back start edge is not missed.
                        if (phase_q == 3'd5) begin
                            if (vote_s) begin
                                rx_data_q   <= shift_q;
                                rx_strobe_q <= 1'b1;
                                state_q     <= S_IDLE;
                                busy_q      <= 1'b0;
                            end else begin
                                framing_err_q <= 1'b1;
                                state_q       <= S_BREAK;
                            end
                        end
                    end
                    S_BREAK: begin
                        if (rxd_s) begin
                            state_q <= S_IDLE;
                            armed_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        armed_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_strobe   = rx_strobe_q;
    assign framing_err = framing_err_q;
    assign busy        = busy_q;

endmodule

// File: doc/uart_rx_8x.md
Name: uart_rx_8x

Overview:
UART receiver for the USB-UART path. It consumes the Baud8Tick strobe produced by Baud8Gen, which runs at 8x the baud rate. It synchronises the serial input, detects and validates start bits, majority-votes each bit, and presents received bytes (8N1, LSB first) as a held data word with a one-cycle strobe. It is the receive-side counterpart of the BaudTick-driven transmit path.

Parameters:
DATA_BITS, 8, data bits per frame (5..8); rx_data bits above DATA_BITS read 0
SYNC_STAGES, 2, flip-flops in the rxd synchroniser (>=2)

Ports:
sys_clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
baud8_tick  in  1  one-sys_clk-wide pulse at 8x baud (from Baud8Gen)
rxd  in  1  asynchronous serial line, idle high
rx_data  out  8  last good byte; held until the next good frame
rx_strobe  out  1  one-cycle pulse: rx_data just updated
framing_err  out  1  one-cycle pulse: stop bit sampled low
busy  out  1  high while a frame is in progress (any state except IDLE)

Behaviour:
- Reset (async assert, sync release): rx_data=0, rx_strobe=0, framing_err=0, busy=0, FSM=IDLE, synchroniser flops=1, armed=0.
- rxd passes through SYNC_STAGES flops; rxd_s is the synchronised value. All FSM and counter activity advances only in cycles where baud8_tick=1. Between ticks, all state holds.
- 3-bit phase counter numbers the ticks within a bit: 0..7. Samples are taken at phases 3, 4 and 5; the bit value is the majority of those 3 samples, decided at phase 5. The counter wraps 7->0 into the next bit.
- armed: set on any tick with rxd_s=1 while in IDLE. Cleared on leaving IDLE and on reset. This blocks false starts when the line is low at reset release.
- States:
  - IDLE: on a tick with armed=1 and rxd_s=0 -> START, phase=0 (that tick is phase 0).
  - START: at phase 5, vote=1 -> IDLE (false start, no outputs); vote=0 -> continue. After phase 7 -> DATA, bit index=0.
  - DATA: vote at phase 5 shifts into the shift register LSB-first. After phase 7 of bit DATA_BITS-1 -> STOP.
  - STOP: decision at phase 5.
    - vote=1 -> rx_data<=shift register, rx_strobe=1 for exactly one sys_clk, -> IDLE. IDLE is entered at phase 5 so the next start edge can be caught early; armed is set on the next high tick.
    - vote=0 -> framing_err=1 for one sys_clk, rx_data unchanged, -> BREAK.
  - BREAK: stay until a tick with rxd_s=1 -> IDLE (armed set on that tick).
- Latency: rx_strobe and framing_err are registered. They are high in the cycle after the sys_clk edge that processes the STOP phase-5 tick. Including synchroniser delay, the strobe occurs about 9.5 bit periods after the start edge.
- rx_strobe and framing_err are never high together. Outputs are unaffected by false starts.
- Back-to-back frames (one stop bit, no idle gap) are received with no loss.
- Reset mid-frame discards the partial frame. Reception restarts only after rxd_s has been seen high on at least one tick.
- baud8_tick held high continuously is legal: each cycle counts as a tick.

Test Plan:
- Tick every 4 sys_clk (37 ns period), 8N1 frame 0x55 -> one rx_strobe, rx_data=0x55, framing_err never high, busy returns to 0.
- Frames 0xA3 then 0x00 back-to-back with no idle gap -> two strobes exactly 10 bit periods apart; rx_data=0xA3, then 0x00.
- rxd low for 2 ticks only, then high -> no strobe and no framing_err, busy high for <=6 ticks; a following 0x3C frame is received correctly.
- Data 0xFF with stop bit driven low -> framing_err pulse, no strobe, rx_data keeps its prior value. Line held low 20 further ticks (no new frame detected), then high; next frame 0x81 -> strobe with 0x81.
- rst pulsed during bit 3 of a 0x5A frame with rxd low at release -> all outputs 0 immediately. No start is detected until rxd goes high; a fresh 0x5A frame -> strobe with 0x5A.
- Frame 0x00 with the phase-4 sample of bit 2 inverted (single-tick glitch) -> majority vote corrects it, rx_data=0x00; the same glitch on the start bit still yields a valid frame.
